gal_sop_term_sequencer: RTL
===========================

// Module: gal_sop_term_sequencer
// PURPOSE
//  Time-multiplexed evaluator for one GAL_SOP-style sum-of-products table. It uses one product-term comparator
//  and steps through up to MAX_DEPTH terms, one term per clock. The table is loaded at runtime through a config port.
//  Operands enter on a valid/ready input; the result Y, the first matching term and a hit flag leave on a
//  valid/ready output. Serves as a simulation/FPGA stand-in for a GAL macrocell.
// PARAMETERS
//  WIDTH      8   input vector width (A), >=1
//  MAX_DEPTH  16  product-term storage entries, >=1
//  AW         $clog2(MAX_DEPTH) (min 1)  derived localparam, term index width
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  cfg_we       in   1          write term cfg_addr with cfg_data
//  cfg_addr     in   AW         term index
//  cfg_data     in   2*WIDTH    term pattern, 2 bits per input: bits[2i+1:2i]
//  cfg_depth_we in   1          load active term count
//  cfg_depth    in   AW+1       number of active terms (0..MAX_DEPTH)
//  cfg_err      out  1          1-cycle pulse: rejected/clamped config access
//  in_valid     in   1          operand valid
//  in_ready     out  1          high only in IDLE
//  in_a         in   WIDTH      operand vector
//  out_valid    out  1          result valid, held until out_ready
//  out_ready    in   1          consumer accepts result
//  out_y        out  1          OR of all matching terms
//  out_term     out  AW         index of lowest-numbered matching term (0 if none)
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  - Term pattern per input i: 2'b00 don't care; 2'b01 requires A[i]==0; 2'b10 requires A[i]==1.
//    2'b11 is a contradiction: the term never matches.
//  - Reset (async assert, sync deassert by the clock domain): state=IDLE; depth=0; out_valid, out_y, out_term,
//    cfg_err=0; in_ready=1; busy=0. Term RAM is not reset. Reset mid-evaluation aborts and discards the result.
//  - FSM IDLE->EVAL->DONE->IDLE.
//    IDLE: in_valid&&in_ready captures in_a into a_q, idx=0, acc=0, goes to EVAL.
//    EVAL: each cycle compares term[idx] against a_q and ORs the result into acc. The first match latches out_term.
//          If idx>=depth-1 (or depth==0, which compares nothing), goes to DONE; else idx++.
//    DONE: out_valid=1, out_y=acc. On out_ready, clears out_valid and goes to IDLE; the next accept is possible
//          one cycle later.
//  - Latency: accept on edge 0; out_valid visible after edge max(depth,1). Throughput is 1 result per
//    max(depth,1)+2 cycles with out_ready tied high.
//  - Config: cfg_we/cfg_depth_we take effect only in IDLE. In EVAL/DONE they are dropped and cfg_err pulses.
//    When both strobes arrive in the same IDLE cycle, both are applied.
//    cfg_depth>MAX_DEPTH saturates to MAX_DEPTH and cfg_err pulses.
//    In IDLE, a config write in the same cycle as an accept is applied. The accepted evaluation uses the new value.
//  - depth==0: out_y=0, out_term=0.
//  - idx never wraps; stops at depth-1.
// CONFIGURATION
//  GAL_SOP_EARLY_EXIT_EN defined: EVAL goes to DONE in the cycle after the first match, so latency is k+1 for
//    a match at term k. Unmatched results keep the full latency.
//  Not defined: all depth terms are always scanned and latency is fixed at max(depth,1). out_y/out_term are
//    identical in both builds.
// TESTING
//  - Reset: assert rst_n=0 mid-EVAL -> out_valid=0, busy=0, in_ready=1; after release, a depth-0 eval gives out_y=0.
//  - NOT: WIDTH=8, term0=16'h0001 (A[0]==0), depth=1, in_a=8'h00 -> out_y=1, out_term=0, out_valid after edge 1;
//    in_a=8'h01 -> out_y=0.
//  - Multi-term: depth=4, term2=16'h0002 (A[0]==1), others=16'hFFFF; in_a=8'h01 -> out_y=1, out_term=2.
//    Latency 4 without the macro, 3 with GAL_SOP_EARLY_EXIT_EN.
//  - Backpressure: hold out_ready=0 for 5 cycles -> out_valid, out_y stable, in_ready=0; a new in_valid is not accepted.
//  - Config during busy: cfg_we in EVAL -> cfg_err pulses 1 cycle, RAM unchanged (re-read via eval).
//    cfg_depth=MAX_DEPTH+1 in IDLE -> depth=MAX_DEPTH, cfg_err pulses.
//  - Contradiction: depth=MAX_DEPTH, all terms 16'hFFFF except last=16'h0000 -> out_y=1, out_term=MAX_DEPTH-1,
//    latency MAX_DEPTH.

Source files
------------

// File: rtl/gal_sop_term_sequencer.sv
// gal_sop_term_sequencer: time-multiplexed sum-of-products evaluator, one product term per clock.
// Optional GAL_SOP_EARLY_EXIT_EN stops the scan at the first matching term.
module gal_sop_term_sequencer #(
   parameter int WIDTH = 8,
   parameter int MAX_DEPTH = 16,
   localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [2*WIDTH-1:0] cfg_data,
   input  logic               cfg_depth_we,
   input  logic [AW:0]        cfg_depth,
   output logic               cfg_err,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_y,
   output logic [AW-1:0]      out_term,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
   localparam logic [AW:0] MAXD = (AW+1)'(MAX_DEPTH);
   state_t state, state_nx;
   logic [2*WIDTH-1:0] mem [MAX_DEPTH];
   logic [2*WIDTH-1:0] term;
   logic [WIDTH-1:0] a_q, hi, lo;
   logic [AW:0] depth;
   logic [AW-1:0] idx;
   logic acc, hit, cmp, last, early, idle, accept, addr_ok;
   assign idle = state == IDLE;
   assign in_ready = idle;
   assign busy = !idle;
   assign out_valid = state == DONE;
   assign out_y = acc;
   assign accept = in_valid && idle;
   assign addr_ok = {1'b0, cfg_addr} < MAXD;
   assign term = mem[idx];
   always_comb begin
      hi = '0;
      lo = '0;
      for (int i = 0; i < WIDTH; i++) begin
         hi[i] = term[2*i+1];
         lo[i] = term[2*i];
      end
   end
   // 2'b10 needs a 1, 2'b01 needs a 0; 2'b11 trips both and can never match
   assign hit = ~|((hi & ~a_q) | (lo & a_q));
   assign cmp = hit && (depth != '0);
   assign last = ({1'b0, idx} + (AW+1)'(1)) >= depth;
`ifdef GAL_SOP_EARLY_EXIT_EN
   assign early = cmp;
`else
   assign early = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      if (idle && accept) state_nx = EVAL;
      else if (state == EVAL && (last || early)) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (idle && cfg_we && addr_ok) mem[cfg_addr] <= cfg_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         depth <= '0;
         a_q <= '0;
         idx <= '0;
         acc <= 1'b0;
         out_term <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= (!idle && (cfg_we || cfg_depth_we)) ||
                    (idle && cfg_depth_we && cfg_depth > MAXD) ||
                    (idle && cfg_we && !addr_ok);
         if (idle && cfg_depth_we) depth <= (cfg_depth > MAXD) ? MAXD : cfg_depth;
         if (accept) begin
            a_q <= in_a;
            idx <= '0;
            acc <= 1'b0;
            out_term <= '0;
         end else if (state == EVAL) begin
            acc <= acc | cmp;
            if (cmp && !acc) out_term <= idx;
            if (!last) idx <= idx + AW'(1);
         end
      end
endmodule
